// File: rtl/tx_pkg.sv
// Shared constants and state encoding for the Tx frame scheduler.
// Mode codes are one-hot on MODE_CTRL; frame_mode uses the 2-bit FM_* codes.
package tx_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  localparam logic [1:0] FM_BPSK = 2'b01;
  localparam logic [1:0] FM_QPSK = 2'b10;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPre  = 3'd1,
    StHdr  = 3'd2,
    StPay  = 3'd3,
    StGap  = 3'd4
  } tx_state_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] fm, input logic [1:0] seq);
    return {HDR_MAGIC, fm, seq};
  endfunction

endpackage

// File: rtl/tx_frame_sched.sv
// Frame scheduler: preamble, header, fixed-length payload (padded on source underrun), then gap.
// All modulator-side outputs come straight from registers; only s_tready is combinational.
module tx_frame_sched
  import tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter int unsigned PAYLOAD_LEN   = 16,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  parameter int unsigned GAP_CYCLES    = 32
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic        tx_en,
  input  logic [3:0]  MODE_CTRL,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  output logic [7:0]  data_tdata,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic        data_tuser,
  output logic        data_tlast,
  output logic [1:0]  frame_mode,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] frames_sent
);

  localparam logic [7:0] PreLast = 8'(PREAMBLE_LEN);
  localparam logic [7:0] PayLast = 8'(PAYLOAD_LEN);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);

  tx_state_e   state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic [1:0]  fm_q, fm_d;
  logic        mix_qpsk_q, mix_qpsk_d;
  logic [1:0]  seq_q, seq_d;
  logic [15:0] frames_q, frames_d;
  logic        uf_q, uf_d;

  logic hs;
  logic next_is_pay;
  logic [7:0] pay_byte;

  assign hs          = tvalid_q & data_tready;
  assign next_is_pay = (state_q == StHdr) | ((state_q == StPay) & ~tlast_q);
  assign s_tready    = hs & next_is_pay & s_tvalid;
  assign pay_byte    = s_tvalid ? s_tdata : PAD_BYTE;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tuser_d    = tuser_q;
    tlast_d    = tlast_q;
    fm_d       = fm_q;
    mix_qpsk_d = mix_qpsk_q;
    seq_d      = seq_q;
    frames_d   = frames_q;
    uf_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (tx_en && s_tvalid) begin
          case (MODE_CTRL)
            MODE_QPSK: fm_d = FM_QPSK;
            MODE_MIX: begin
              fm_d       = mix_qpsk_q ? FM_QPSK : FM_BPSK;
              mix_qpsk_d = ~mix_qpsk_q;
            end
            default:   fm_d = FM_BPSK;
          endcase
          tdata_d    = PREAMBLE_BYTE;
          tvalid_d   = 1'b1;
          tuser_d    = 1'b1;
          tlast_d    = 1'b0;
          byte_cnt_d = 8'd1;
          state_d    = StPre;
        end
      end

      StPre: begin
        if (hs) begin
          tuser_d = 1'b0;
          if (byte_cnt_q == PreLast) begin
            tdata_d = hdr_byte(fm_q, seq_q);
            state_d = StHdr;
          end else begin
            tdata_d    = PREAMBLE_BYTE;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
      end

      StHdr: begin
        if (hs) begin
          tdata_d    = pay_byte;
          uf_d       = ~s_tvalid;
          byte_cnt_d = 8'd1;
          tlast_d    = (PayLast == 8'd1);
          state_d    = StPay;
        end
      end

      StPay: begin
        if (hs) begin
          if (tlast_q) begin
            tvalid_d   = 1'b0;
            tlast_d    = 1'b0;
            seq_d      = seq_q + 2'd1;
            frames_d   = frames_q + 16'd1;
            byte_cnt_d = 8'd0;
            state_d    = (GAP_CYCLES == 0) ? StIdle : StGap;
          end else begin
            tdata_d    = pay_byte;
            uf_d       = ~s_tvalid;
            byte_cnt_d = byte_cnt_q + 8'd1;
            tlast_d    = ((byte_cnt_q + 8'd1) == PayLast);
          end
        end
      end

      // Gap length is independent of data_tready; the modulator sees tvalid=0 throughout.
      StGap: begin
        if (byte_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          byte_cnt_d = byte_cnt_q + 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      state_q    <= StIdle;
      byte_cnt_q <= 8'd0;
      tdata_q    <= 8'd0;
      tvalid_q   <= 1'b0;
      tuser_q    <= 1'b0;
      tlast_q    <= 1'b0;
      fm_q       <= FM_BPSK;
      mix_qpsk_q <= 1'b0;
      seq_q      <= 2'd0;
      frames_q   <= 16'd0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tuser_q    <= tuser_d;
      tlast_q    <= tlast_d;
      fm_q       <= fm_d;
      mix_qpsk_q <= mix_qpsk_d;
      seq_q      <= seq_d;
      frames_q   <= frames_d;
      uf_q       <= uf_d;
    end
  end

  assign data_tdata  = tdata_q;
  assign data_tvalid = tvalid_q;
  assign data_tuser  = tuser_q;
  assign data_tlast  = tlast_q;
  assign frame_mode  = fm_q;
  assign busy        = (state_q != StIdle);
  assign underflow   = uf_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Randomised bench for tx_frame_sched against a byte-position reference model of each frame.
module tb_tx_frame_sched;

  localparam int P = 4;
  localparam int L = 16;
  localparam int G = 32;
  localparam int F = P + 1 + L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [3:0]  mode_ctrl = 4'b0001;
  logic [7:0]  s_tdata = 8'd1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tready = 1'b1;
  logic        data_tuser;
  logic        data_tlast;
  logic [1:0]  frame_mode;
  logic        busy;
  logic        underflow;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  tx_frame_sched dut (
    .clk_16M384  (clk),
    .rst_16M384  (rst),
    .tx_en       (tx_en),
    .MODE_CTRL   (mode_ctrl),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .data_tdata  (data_tdata),
    .data_tvalid (data_tvalid),
    .data_tready (data_tready),
    .data_tuser  (data_tuser),
    .data_tlast  (data_tlast),
    .frame_mode  (frame_mode),
    .busy        (busy),
    .underflow   (underflow),
    .frames_sent (frames_sent)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position of the byte on the bus within its frame (0 = none).
  int         m_idx = 0;
  int         m_gap = 0;
  bit         m_busy = 0;
  bit         m_uf = 0;
  bit         m_mix_q = 0;
  bit         m_live = 0;
  logic [1:0] m_fm = 2'b01;
  logic [1:0] m_seq = 2'd0;
  logic [15:0] m_frames = 16'd0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] m_src = 8'd1;

  logic [7:0] drv_src = 8'd1;
  bit         take = 0;
  int         sv_pol = 0;
  int         tr_pol = 0;
  int         uf_seen = 0;

  function automatic logic [7:0] next_src(input logic [7:0] v);
    return (v == 8'd255) ? 8'd1 : v + 8'd1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_idx = 0; m_gap = 0; m_busy = 0; m_uf = 0; m_mix_q = 0;
      m_fm = 2'b01; m_seq = 2'd0; m_frames = 16'd0; m_live = 1;
    end else if (m_idx == 0) begin
      m_uf = 0;
      if (m_busy) begin
        m_gap--;
        if (m_gap == 0) m_busy = 0;
      end else if (tx_en && s_tvalid) begin
        if (mode_ctrl == 4'b0010) m_fm = 2'b10;
        else if (mode_ctrl == 4'b0100) begin
          m_fm = m_mix_q ? 2'b10 : 2'b01;
          m_mix_q = !m_mix_q;
        end else m_fm = 2'b01;
        m_idx = 1; m_byte = 8'h55; m_busy = 1;
      end
    end else begin
      m_uf = 0;
      if (data_tready) begin
        if (m_idx == F) begin
          m_idx = 0; m_seq = m_seq + 2'd1; m_frames = m_frames + 16'd1;
          if (G > 0) m_gap = G; else m_busy = 0;
        end else begin
          m_idx++;
          if (m_idx <= P) m_byte = 8'h55;
          else if (m_idx == P + 1) m_byte = {4'hA, m_fm, m_seq};
          else if (s_tvalid) begin
            m_byte = m_src;
            m_src = next_src(m_src);
          end else begin
            m_byte = 8'h00;
            m_uf = 1;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = data_tready && (m_idx >= P + 1) && (m_idx < F) && s_tvalid;
    if (m_live) begin
      check_val("tvalid", data_tvalid, m_idx != 0);
      check_val("busy", busy, m_busy);
      check_val("underflow", underflow, m_uf);
      check_val("frames_sent", frames_sent, m_frames);
      check_val("s_tready", s_tready, exp_rdy);
      check_val("frame_mode", frame_mode, m_fm);
      if (m_idx != 0) begin
        check_val("tdata", data_tdata, m_byte);
        check_val("tuser", data_tuser, m_idx == 1);
        check_val("tlast", data_tlast, m_idx == F);
      end
    end
    if (underflow === 1'b1) uf_seen++;
    take = !rst && s_tvalid && (s_tready === 1'b1);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    if (take) drv_src = next_src(drv_src);
    s_tdata = drv_src;
    case (sv_pol)
      1:       s_tvalid = !(m_idx >= P + 5 && m_idx <= P + 7);
      2:       s_tvalid = ($urandom_range(0, 3) != 0);
      default: s_tvalid = 1'b1;
    endcase
    data_tready = (tr_pol == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive_inputs();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) begin
      drive_inputs();
      cycle();
    end
    rst = 1'b0;

    // 1: BPSK, no stalls, continuous source; second frame header carries seq=1
    tx_en = 1'b1; mode_ctrl = 4'b0001;
    for (int n = 0; n < 300 && !(m_frames == 1 && m_idx == P + 1); n++) begin
      drive_inputs(); cycle();
    end
    check_val("s1_hdr2", data_tdata, 8'hA5);
    check_val("s1_frames", frames_sent, 1);

    // 2: MIX alternates BPSK/QPSK starting with BPSK
    mode_ctrl = 4'b0100;
    pulse_reset();
    for (int n = 0; n < 600 && m_frames != 3; n++) begin
      drive_inputs(); cycle();
    end
    check_val("s2_frames", frames_sent, 3);

    // 3: source gap on payload bytes 5..7
    mode_ctrl = 4'b0001; sv_pol = 1;
    pulse_reset();
    uf_seen = 0;
    for (int n = 0; n < 300 && m_frames != 1; n++) begin
      drive_inputs(); cycle();
    end
    check_val("s3_underflows", uf_seen, 3);
    check_val("s3_frames", frames_sent, 1);

    // 4: random back-pressure
    sv_pol = 0; tr_pol = 1;
    pulse_reset();
    for (int n = 0; n < 1000 && m_frames != 2; n++) begin
      drive_inputs(); cycle();
    end
    check_val("s4_frames", frames_sent, 2);

    // 5: tx_en falls mid-payload, illegal mode value decodes as BPSK
    tr_pol = 0; mode_ctrl = 4'b1000;
    pulse_reset();
    for (int n = 0; n < 300 && !(m_frames == 1 && !m_busy); n++) begin
      drive_inputs();
      if (m_idx == P + 4) tx_en = 1'b0;
      cycle();
    end
    repeat (40) begin
      drive_inputs(); cycle();
    end
    check_val("s5_busy", busy, 0);
    check_val("s5_frames", frames_sent, 1);
    check_val("s5_mode", frame_mode, 2'b01);

    // 6: reset mid-payload, then MIX restarts at BPSK with random source and stalls
    tx_en = 1'b1; mode_ctrl = 4'b0100;
    pulse_reset();
    for (int n = 0; n < 300 && m_idx != P + 9; n++) begin
      drive_inputs(); cycle();
    end
    pulse_reset();
    check_val("s6_tvalid", data_tvalid, 0);
    check_val("s6_frames", frames_sent, 0);
    sv_pol = 2; tr_pol = 1;
    for (int n = 0; n < 1500 && m_frames != 2; n++) begin
      drive_inputs(); cycle();
    end
    check_val("s6_frames_end", frames_sent, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
